// File: rtl/mult_result_drain_pkg.sv
// Shared definitions for the matmul result drain path: default geometry,
// lane/vector types and the ping-pong occupancy encoding.
package mult_result_drain_pkg;

   localparam int DIM_MULT  = 4;
   localparam int ACC_WIDTH = 24;
   localparam int OUT_WIDTH = 8;
   localparam int REQ_SHIFT = 8;
   localparam int CNT_WIDTH = 16;

   typedef logic signed [ACC_WIDTH-1:0] acc_t;
   typedef logic signed [OUT_WIDTH-1:0] out_t;
   typedef acc_t [DIM_MULT-1:0]         acc_vec_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

endpackage

// File: rtl/mult_result_drain_requant.sv
// Requantizer: round-half-up arithmetic right shift of a signed accumulator
// followed by saturation to a signed OUT_W result, with a saturation flag.
module requant_sat #(
   parameter int ACC_W = 24,
   parameter int OUT_W = 8,
   parameter int SHIFT = 8
) (
   input  logic signed [ACC_W-1:0] x,
   output logic signed [OUT_W-1:0] y,
   output logic                    sat
);

   // One guard bit keeps the rounding addition from overflowing.
   localparam logic signed [ACC_W:0] ONE_C  = {{ACC_W{1'b0}}, 1'b1};
   localparam int                    RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [ACC_W:0] RND_C  = (SHIFT > 0) ? (ONE_C <<< RND_SH) : {(ACC_W+1){1'b0}};
   localparam logic signed [ACC_W:0] MAX_C  = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MIN_C  = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [ACC_W:0] t_s;
   logic signed [ACC_W:0] sh_s;

   assign t_s  = $signed({x[ACC_W-1], x}) + RND_C;
   assign sh_s = t_s >>> SHIFT;

   // Clamp the shifted value into the output range and flag clipping.
   always_comb begin
      y   = {OUT_W{1'b0}};
      sat = 1'b0;
      if (sh_s > MAX_C) begin
         y   = MAX_C[OUT_W-1:0];
         sat = 1'b1;
      end else if (sh_s < MIN_C) begin
         y   = MIN_C[OUT_W-1:0];
         sat = 1'b1;
      end else begin
         y   = sh_s[OUT_W-1:0];
         sat = 1'b0;
      end
   end

endmodule

// File: rtl/mult_result_drain.sv
// Captures adder-tree result vectors into a 2-entry ping-pong buffer and
// drains them one requantized lane per cycle, counting saturated lanes.
module mult_result_drain
   import mult_result_drain_pkg::*;
#(
   parameter int N_LANE = DIM_MULT,
   parameter int ACC_W  = ACC_WIDTH,
   parameter int OUT_W  = OUT_WIDTH,
   parameter int SHIFT  = REQ_SHIFT,
   parameter int CNT_W  = CNT_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [N_LANE-1:0][ACC_W-1:0]   in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [OUT_W-1:0]               out_data,
   output logic [$clog2(N_LANE)-1:0]      out_idx,
   output logic                           out_last,
   output logic [CNT_W-1:0]               sat_cnt,
   input  logic                           sat_clr
);

   localparam int IDX_W = $clog2(N_LANE);

   logic [N_LANE-1:0][ACC_W-1:0] buf_r [2];
   logic                         wr_ptr_r;
   logic                         rd_ptr_r;
   logic [IDX_W-1:0]             lane_r;
   occ_e                         occ_r;

   logic                         acc_s;
   logic                         adv_s;
   logic                         pop_s;
   logic                         last_s;
   logic                         sat_s;
   logic signed [ACC_W-1:0]      lane_data_s;
   logic signed [OUT_W-1:0]      req_s;

   assign in_ready    = (occ_r != OCC_FULL);
   assign out_valid   = (occ_r != OCC_EMPTY);
   assign last_s      = (lane_r == IDX_W'(N_LANE - 1));
   assign acc_s       = in_valid & in_ready;
   assign adv_s       = out_valid & out_ready;
   assign pop_s       = adv_s & last_s;
   assign lane_data_s = buf_r[rd_ptr_r][lane_r];

   requant_sat #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_requant (
      .x   (lane_data_s),
      .y   (req_s),
      .sat (sat_s)
   );

   // Output view; data and last are forced to zero while nothing is buffered.
   always_comb begin
      out_idx = lane_r;
      if (out_valid) begin
         out_data = req_s;
         out_last = last_s;
      end else begin
         out_data = {OUT_W{1'b0}};
         out_last = 1'b0;
      end
   end

   // Ping-pong capture: only the slot addressed by wr_ptr is written, on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            buf_r[i] <= '0;
         end
      end else if (acc_s) begin
         buf_r[wr_ptr_r] <= in_data;
      end
   end

   // Pointer, lane counter and occupancy control.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         lane_r   <= {IDX_W{1'b0}};
         occ_r    <= OCC_EMPTY;
      end else begin
         if (acc_s) begin
            wr_ptr_r <= ~wr_ptr_r;
         end
         if (adv_s) begin
            if (last_s) begin
               lane_r   <= {IDX_W{1'b0}};
               rd_ptr_r <= ~rd_ptr_r;
            end else begin
               lane_r   <= lane_r + IDX_W'(1);
            end
         end
         // A simultaneous accept and final-lane pop leaves occupancy unchanged.
         case ({acc_s, pop_s})
            2'b10:   occ_r <= (occ_r == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
            2'b01:   occ_r <= (occ_r == OCC_FULL)  ? OCC_ONE : OCC_EMPTY;
            default: occ_r <= occ_r;
         endcase
      end
   end

   // Saturation counter: sticky at all-ones, clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt <= {CNT_W{1'b0}};
      end else if (sat_clr) begin
         sat_cnt <= {CNT_W{1'b0}};
      end else if (adv_s && sat_s && (sat_cnt != {CNT_W{1'b1}})) begin
         sat_cnt <= sat_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mult_result_drain.sv
// Self-checking bench for mult_result_drain: table-driven vectors plus
// back-pressure, random-stall scoreboard, mid-drain reset and identity cases.
module tb_mult_result_drain;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, out_last, sat_clr;
   logic [95:0] in_data;
   logic [7:0]  out_data;
   logic [1:0]  out_idx;
   logic [15:0] sat_cnt;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_sat_clr;
   logic [95:0] b_in_data;
   logic [23:0] b_out_data;
   logic [1:0]  b_out_idx;
   logic [15:0] b_sat_cnt;

   mult_result_drain #(.N_LANE(4), .ACC_W(24), .OUT_W(8), .SHIFT(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
      .out_last(out_last), .sat_cnt(sat_cnt), .sat_clr(sat_clr));

   mult_result_drain #(.N_LANE(4), .ACC_W(24), .OUT_W(24), .SHIFT(0), .CNT_W(16)) dut_id (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_idx(b_out_idx),
      .out_last(b_out_last), .sat_cnt(b_sat_cnt), .sat_clr(b_sat_clr));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int x[4];
      int y[4];
      int sat;
   } vec_t;

   typedef struct {
      int y;
      int idx;
      bit sat;
   } exp_t;

   vec_t tbl[4];
   exp_t q[$];
   exp_t mon_e;
   int   exp_sat = 0;

   function automatic int model(input int x, output bit s);
      longint t, y;
      t = longint'(x) + 64'sd128;
      y = t >>> 8;
      s = 1'b0;
      if (y > 64'sd127) begin
         s = 1'b1;
         return 127;
      end else if (y < -64'sd128) begin
         s = 1'b1;
         return -128;
      end
      return int'(y);
   endfunction

   function automatic logic [95:0] pack(input int x[4]);
      logic [95:0] p;
      for (int l = 0; l < 4; l++) p[l*24 +: 24] = x[l][23:0];
      return p;
   endfunction

   task automatic enqueue(input logic [95:0] d);
      exp_t e;
      logic signed [23:0] v;
      for (int l = 0; l < 4; l++) begin
         v     = d[l*24 +: 24];
         e.y   = model(int'(v), e.sat);
         e.idx = l;
         q.push_back(e);
      end
   endtask

   task automatic push(input logic [95:0] d);
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("push_timeout", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Scoreboard and stall-stability monitor.
   logic        mon_en = 1'b0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data;
   logic [1:0]  prev_idx;
   logic        prev_last;
   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_stall) begin
            chk("stall_data", out_data, prev_data);
            chk("stall_idx",  out_idx,  prev_idx);
            chk("stall_last", out_last, prev_last);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_lane", q.size(), 1);
            end else begin
               mon_e = q.pop_front();
               chk("sb_data", $signed(out_data), mon_e.y);
               chk("sb_idx",  out_idx, mon_e.idx);
               chk("sb_last", out_last, (mon_e.idx == 3) ? 1 : 0);
               if (mon_e.sat) exp_sat++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_idx   = out_idx;
         prev_last  = out_last;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int tbl_sat;
      int n;
      int tmp[4];
      logic [95:0] v0, v1, v2;
      logic [23:0] idv[4];
      logic signed [23:0] s;
      logic [31:0] r;
      bit dsat;
      bit drv_done;

      tbl[0].x = '{256, 384, -384, 0};          tbl[0].y = '{1, 2, -1, 0};         tbl[0].sat = 0;
      tbl[1].x = '{40000, -40000, 32767, -32768}; tbl[1].y = '{127, -128, 127, -128}; tbl[1].sat = 3;
      tbl[2].x = '{127, 128, -129, -128};       tbl[2].y = '{0, 1, -1, 0};         tbl[2].sat = 0;
      tbl[3].x = '{32639, 32640, -32896, -32897}; tbl[3].y = '{127, 127, -128, -128}; tbl[3].sat = 2;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sat_clr = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_sat_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_sat_cnt", sat_cnt, 0);
      rst_n = 1'b1;

      // Table: one vector at a time, out_ready high, lane 0 the cycle after accept.
      out_ready = 1'b1;
      tbl_sat = 0;
      for (int i = 0; i < 4; i++) begin
         push(pack(tbl[i].x));
         for (int l = 0; l < 4; l++) begin
            @(negedge clk);
            chk("tbl_valid", out_valid, 1);
            chk("tbl_idx", out_idx, l);
            chk("tbl_data", $signed(out_data), tbl[i].y[l]);
            chk("tbl_last", out_last, (l == 3) ? 1 : 0);
         end
         tbl_sat += tbl[i].sat;
         @(negedge clk);
         chk("tbl_empty", out_valid, 0);
         chk("tbl_sat_cnt", sat_cnt, tbl_sat);
      end
      @(posedge clk); #1 sat_clr = 1'b1;
      @(posedge clk); #1 sat_clr = 1'b0;
      @(negedge clk);
      chk("sat_clr", sat_cnt, 0);

      // Back-pressure: third vector waits for the first vector's final lane.
      mon_en = 1'b1;
      exp_sat = 0;
      out_ready = 1'b0;
      tmp = '{256, 512, 768, 1024};   v0 = pack(tmp);
      tmp = '{-256, -512, 50000, 5};  v1 = pack(tmp);
      tmp = '{1000, -1000, 130, -130}; v2 = pack(tmp);
      @(posedge clk); #1 in_valid = 1'b1; in_data = v0; enqueue(v0);
      @(posedge clk); #1 in_data = v1; enqueue(v1);
      @(posedge clk); #1 in_data = v2;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_full", in_ready, 0);
      end
      chk("bp_hold_idx", out_idx, 0);
      @(posedge clk); #1 out_ready = 1'b1; enqueue(v2);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_still_full", in_ready, 0);
         chk("bp_last", out_last, (k == 3) ? 1 : 0);
      end
      @(negedge clk);
      chk("bp_slot_freed", in_ready, 1);
      @(posedge clk); #1 in_valid = 1'b0;
      n = 0;
      while (q.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_drained", q.size(), 0);

      // Random out_ready with continuous in_valid over 50 vectors.
      drv_done = 1'b0;
      fork
         begin
            @(posedge clk); #1;
            for (int v = 0; v < 50; v++) begin
               for (int l = 0; l < 4; l++) begin
                  r = $urandom;
                  s = r[23:0];
                  s = s >>> $urandom_range(0, 12);
                  tmp[l] = int'(s);
               end
               in_valid = 1'b1;
               in_data  = pack(tmp);
               enqueue(in_data);
               n = 0;
               @(negedge clk);
               while (!in_ready && n < 500) begin
                  @(negedge clk);
                  n++;
               end
               if (!in_ready) chk("rnd_push_timeout", in_ready, 1);
               @(posedge clk); #1;
            end
            in_valid = 1'b0;
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      n = 0;
      while (q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rnd_drained", q.size(), 0);
      repeat (2) @(negedge clk);
      chk("rnd_sat_cnt", sat_cnt, exp_sat);
      mon_en = 1'b0;

      // Reset during lane 2 of A with B buffered.
      out_ready = 1'b0;
      tmp = '{512, 512, 512, 512};  v0 = pack(tmp);
      tmp = '{-512, 9999, 77, 3};   v1 = pack(tmp);
      @(posedge clk); #1 in_valid = 1'b1; in_data = v0;
      @(posedge clk); #1 in_data = v1;
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("mid_idx", out_idx, 2);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_idx", out_idx, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_sat", sat_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      push(pack(tbl[0].x));
      for (int l = 0; l < 4; l++) begin
         @(negedge clk);
         chk("post_rst_valid", out_valid, 1);
         chk("post_rst_idx", out_idx, l);
         chk("post_rst_data", $signed(out_data), tbl[0].y[l]);
      end
      @(negedge clk);
      chk("post_rst_empty", out_valid, 0);

      // Identity configuration: SHIFT=0, OUT_W=ACC_W.
      idv = '{24'h7FFFFF, 24'h800000, 24'hFFFFFF, 24'h000000};
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b1;
      for (int l = 0; l < 4; l++) b_in_data[l*24 +: 24] = idv[l];
      @(negedge clk);
      chk("id_in_ready", b_in_ready, 1);
      @(posedge clk); #1 b_in_valid = 1'b0;
      for (int l = 0; l < 4; l++) begin
         @(negedge clk);
         chk("id_valid", b_out_valid, 1);
         chk("id_idx", b_out_idx, l);
         chk("id_data", b_out_data, idv[l]);
      end
      @(negedge clk);
      chk("id_sat_cnt", b_sat_cnt, 0);
      dsat = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
